// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one synchronous RAM between instruction fetch and
// data access, with a byte-wide MMIO output register at MMIO_ADDR.
module mem_arbiter #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] MMIO_ADDR = 32'h0000_0400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_WAIT = 2'd1,
        ST_D_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_grant;   // 1 = data won last, 0 = fetch won last
    logic        r_d_mmio;
    logic        r_mmio_wr;
    logic [7:0]  r_tx_data;

    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_d_is_mmio;
    logic        w_unused_bits;

    assign w_d_is_mmio   = (d_addr == MMIO_ADDR);
    assign w_unused_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0]};

    // Grant decision and next state; requests are only looked at in IDLE.
    always_comb begin
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req && d_req) begin
                    w_grant_i = r_last_grant;
                    w_grant_d = !r_last_grant;
                end else begin
                    w_grant_i = i_req;
                    w_grant_d = d_req;
                end
                if (w_grant_i) begin
                    w_state_nxt = ST_I_WAIT;
                end else if (w_grant_d) begin
                    w_state_nxt = ST_D_WAIT;
                end
            end
            ST_I_WAIT: w_state_nxt = ST_IDLE;
            ST_D_WAIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_d_mmio     <= 1'b0;
            r_mmio_wr    <= 1'b0;
            r_tx_data    <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_i) begin
                r_last_grant <= 1'b0;
            end
            if (w_grant_d) begin
                r_last_grant <= 1'b1;
                r_d_mmio     <= w_d_is_mmio;
                r_mmio_wr    <= w_d_is_mmio && d_we;
                if (w_d_is_mmio && d_we) begin
                    r_tx_data <= d_wdata[7:0];
                end
            end
        end
    end

    // RAM side is driven combinationally in the grant cycle; reset masks it at once.
    always_comb begin
        ram_en    = rst_n && (w_grant_i || (w_grant_d && !w_d_is_mmio));
        ram_we    = ram_en && w_grant_d && d_we;
        ram_addr  = w_grant_d ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
        ram_wdata = w_grant_d ? d_wdata : 32'h0;
    end

    always_comb begin
        i_ready  = (r_state == ST_I_WAIT);
        d_ready  = (r_state == ST_D_WAIT);
        i_rdata  = i_ready ? ram_rdata : 32'h0;
        d_rdata  = (d_ready && !r_d_mmio) ? ram_rdata : 32'h0;
        tx_valid = d_ready && r_mmio_wr;
        tx_data  = r_tx_data;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter, checked against a transaction-level
// model of the arbiter and a reference memory.
module tb_mem_arbiter;

    localparam logic [31:0] MMIO = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        i_ready, d_ready, ram_en, ram_we, tx_valid;
    logic [9:0]  ram_addr;
    logic [7:0]  tx_data;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int a);
        return (a == 2) ? 32'h0010_8093 : (a * 32'h9E37_79B1 + 32'h0123_4567);
    endfunction

    // Synchronous RAM the DUT talks to.
    logic [31:0] ram [1024];
    bit          ram_written [1024];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram[ram_addr]         <= ram_wdata;
                ram_written[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= ram_written[ram_addr] ? ram[ram_addr] : init_val(int'(ram_addr));
            end
        end
    end

    // Reference model: memory contents plus the one access currently owed a ready pulse.
    logic [31:0] ref_mem [int];
    int          m_owe = 0;          // 0 nothing owed, 1 fetch owed, 2 data owed
    bit          m_last_data = 1'b1; // most recent winner was the data port
    int          m_addr = 0;
    bit          m_mmio = 1'b0;
    bit          m_we = 1'b0;
    logic [7:0]  m_tx = 8'h00;

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % 1024);
    endfunction

    function automatic logic [31:0] mem_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model past the rising edge.
    task automatic step(output bit saw_i, output bit saw_d);
        int w;
        bit chk_drd;
        logic [31:0] e_en, e_we, e_addr, e_wd, e_ir, e_ird, e_dr, e_drd, e_txv, e_tx;
        logic [31:0] s_ia, s_da, s_dwd;
        bit s_dwe, s_rst;
        @(negedge clk);
        w = 0; chk_drd = 1'b1;
        e_en = 0; e_we = 0; e_addr = 0; e_wd = 0; e_ir = 0; e_ird = 0;
        e_dr = 0; e_drd = 0; e_txv = 0;
        e_tx = rst_n ? {24'h0, m_tx} : 32'h0;
        if (rst_n) begin
            if (m_owe == 0) begin
                if (i_req && d_req) w = m_last_data ? 1 : 2;
                else if (i_req)     w = 1;
                else if (d_req)     w = 2;
                if (w == 1) begin
                    e_en = 1; e_addr = word_of(i_addr);
                end else if (w == 2 && d_addr != MMIO) begin
                    e_en = 1; e_we = {31'h0, d_we}; e_addr = word_of(d_addr); e_wd = d_wdata;
                end
            end else if (m_owe == 1) begin
                e_ir = 1; e_ird = mem_rd(m_addr);
            end else begin
                e_dr = 1;
                if (m_mmio) e_drd = 0;
                else if (m_we) chk_drd = 1'b0;
                else e_drd = mem_rd(m_addr);
                e_txv = {31'h0, m_mmio && m_we};
            end
        end
        chk("ram_en", {31'h0, ram_en}, e_en);
        chk("ram_we", {31'h0, ram_we}, e_we);
        if (e_en != 0) chk("ram_addr", {22'h0, ram_addr}, e_addr);
        if (e_we != 0) chk("ram_wdata", ram_wdata, e_wd);
        chk("i_ready", {31'h0, i_ready}, e_ir);
        chk("i_rdata", i_rdata, e_ird);
        chk("d_ready", {31'h0, d_ready}, e_dr);
        if (chk_drd) chk("d_rdata", d_rdata, e_drd);
        chk("tx_valid", {31'h0, tx_valid}, e_txv);
        chk("tx_data", {24'h0, tx_data}, e_tx);
        saw_i = i_ready; saw_d = d_ready;
        s_ia = i_addr; s_da = d_addr; s_dwd = d_wdata; s_dwe = d_we;
        @(posedge clk);
        #1;
        s_rst = rst_n;
        if (!s_rst) begin
            m_owe = 0; m_last_data = 1'b1; m_tx = 8'h00;
        end else if (m_owe != 0) begin
            m_owe = 0;
        end else if (w == 1) begin
            m_owe = 1; m_addr = word_of(s_ia); m_last_data = 1'b0;
        end else if (w == 2) begin
            m_owe = 2; m_addr = word_of(s_da); m_last_data = 1'b1;
            m_mmio = (s_da == MMIO); m_we = s_dwe;
            if (m_mmio && m_we) m_tx = s_dwd[7:0];
            if (!m_mmio && m_we) ref_mem[m_addr] = s_dwd;
        end
    endtask

    task automatic acc_d(input bit we, input logic [31:0] a, input logic [31:0] wd);
        bit si, sd, done;
        done = 1'b0;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        for (int k = 0; k < 4 && !done; k++) begin
            step(si, sd);
            if (sd) done = 1'b1;
        end
        chk("d_done", {31'h0, done}, 32'h1);
        d_req = 1'b0;
    endtask

    task automatic acc_i(input logic [31:0] a);
        bit si, sd, done;
        done = 1'b0;
        i_req = 1'b1; i_addr = a;
        for (int k = 0; k < 4 && !done; k++) begin
            step(si, sd);
            if (si) done = 1'b1;
        end
        chk("i_done", {31'h0, done}, 32'h1);
        i_req = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        return $urandom & 32'hFFFF_F03F;
    endfunction

    initial begin
        bit si, sd;
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        step(si, sd);
        step(si, sd);

        // Single fetch after reset, word 2 holds 0x00108093.
        rst_n = 1'b1;
        i_req = 1'b1; i_addr = 32'h8;
        step(si, sd);
        chk("fetch_lat1", {31'h0, si}, 32'h0);
        step(si, sd);
        chk("fetch_lat2", {31'h0, si}, 32'h1);
        i_req = 1'b0;
        step(si, sd);

        // Both requesters held from reset: fetch wins first, then strict alternation.
        rst_n = 1'b0;
        step(si, sd);
        rst_n = 1'b1;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14; d_wdata = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            step(si, sd);
            chk("rr_ready", {31'h0, si | sd}, {31'h0, (k % 2) == 0});
            chk("rr_data_turn", {31'h0, sd}, {31'h0, (k % 4) == 0});
        end
        i_req = 1'b0; d_req = 1'b0;
        step(si, sd);

        acc_d(1'b1, MMIO, 32'h0000_0005);
        acc_d(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
        acc_i(32'h0000_0004);
        acc_d(1'b0, MMIO, 32'h0);
        acc_i(MMIO);

        // Reset while a data read is outstanding.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        step(si, sd);
        rst_n = 1'b0; d_req = 1'b0;
        step(si, sd);
        chk("abort_ready", {31'h0, sd}, 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(si, sd);
            chk("no_late_ready", {31'h0, sd}, 32'h0);
        end

        // Randomised traffic obeying the hold-until-ready protocol.
        for (int n = 0; n < 600; n++) begin
            step(si, sd);
            if (rst_n == 1'b0) rst_n = 1'b1;
            else if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
            if (!i_req || si) begin
                i_req = ($urandom_range(0, 2) != 0);
                i_addr = ($urandom_range(0, 9) == 0) ? MMIO : rand_addr();
            end
            if (!d_req || sd) begin
                d_req = ($urandom_range(0, 2) != 0);
                d_we = $urandom_range(0, 1);
                d_addr = ($urandom_range(0, 3) == 0) ? MMIO : rand_addr();
                d_wdata = $urandom;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, RAM word-address width (RAM depth 2**ADDR_W words).
REQ-002 Parameter MMIO_ADDR, default 32'h0000_0400, byte address of the output register.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_req  input  1  instruction-fetch request; held high until i_ready.
REQ-006 i_addr  input  32  fetch byte address; stable while i_req is high.
REQ-007 i_rdata  output  32  fetch read data; valid when i_ready=1.
REQ-008 i_ready  output  1  one-cycle pulse that completes a fetch.
REQ-009 d_req  input  1  data request; held high until d_ready.
REQ-010 d_we  input  1  data write when 1, read when 0; stable while d_req is high.
REQ-011 d_addr  input  32  data byte address; stable while d_req is high.
REQ-012 d_wdata  input  32  write data; stable while d_req is high.
REQ-013 d_rdata  output  32  data read data; valid when d_ready=1.
REQ-014 d_ready  output  1  one-cycle pulse that completes a data access.
REQ-015 ram_en  output  1  RAM access enable.
REQ-016 ram_we  output  1  RAM write enable, qualified by ram_en.
REQ-017 ram_addr  output  ADDR_W  RAM word address.
REQ-018 ram_wdata  output  32  RAM write data.
REQ-019 ram_rdata  input  32  RAM read data, registered, valid the cycle after ram_en.
REQ-020 tx_data  output  8  last byte written to MMIO_ADDR.
REQ-021 tx_valid  output  1  one-cycle pulse when tx_data updates.

Function
REQ-022 FSM states: IDLE, I_WAIT and D_WAIT; a single-bit last_grant register records the most recent winner.
REQ-023 IDLE, only i_req: grant fetch; ram_en=1, ram_we=0, ram_addr=i_addr[ADDR_W+1:2]; next state I_WAIT.
REQ-024 IDLE, only d_req: grant data; ram_addr=d_addr[ADDR_W+1:2], ram_we=d_we, ram_wdata=d_wdata; next state D_WAIT.
REQ-025 IDLE, both requests high: grant the requester not equal to last_grant (round-robin); update last_grant on every grant.
REQ-026 IDLE, no request: ram_en=0; remain in IDLE.
REQ-027 I_WAIT: i_ready=1 and i_rdata=ram_rdata; next state IDLE unconditionally.
REQ-028 D_WAIT: d_ready=1; d_rdata=ram_rdata for RAM reads and 0 for MMIO reads; next state IDLE unconditionally.
REQ-029 Latency: every access takes 2 cycles, the grant cycle followed by the ready cycle; sustained single-requester throughput is one access per 2 cycles.
REQ-030 Request lines are ignored in the WAIT states; a request that is still high in the IDLE cycle after ready is treated as a new request.
REQ-031 MMIO match uses the full 32-bit d_addr == MMIO_ADDR comparison.
REQ-032 MMIO access: ram_en=0 in the grant cycle.
REQ-033 MMIO write: tx_data is loaded with d_wdata[7:0] at the grant edge; tx_valid=1 during the D_WAIT cycle only.
REQ-034 MMIO read: tx_valid is not pulsed.
REQ-035 Fetches to MMIO_ADDR access RAM normally.
REQ-036 Address bits [1:0] and bits above ADDR_W+1 are ignored for RAM access (aliasing).
REQ-037 i_ready and d_ready are never high in the same cycle; ram_en is never high in a WAIT state.
REQ-038 ram_we=0 whenever ram_en=0.
REQ-039 Read data outputs are 0 whenever their ready signal is 0.

Reset
REQ-040 rst_n low forces, immediately: state IDLE, last_grant=data, tx_data=8'h00, tx_valid=0, i_ready=0, d_ready=0, ram_en=0, ram_we=0.
REQ-041 Reset during a WAIT state aborts the access; no ready pulse is emitted for it after release.
REQ-042 The first cycle after release is IDLE; a simultaneous first request is granted to fetch.

Verification
REQ-043 Scenario: after reset, i_req=1, i_addr=0x8, ram_rdata=0x00108093 -> ram_en=1 with ram_addr=2 in cycle 1; i_ready=1 with i_rdata=0x00108093 in cycle 2.
REQ-044 Scenario: i_req and d_req held high from reset -> grants alternate I,D,I,D; ready pulses occur on cycles 2,4,6,8.
REQ-045 Scenario: d_we=1, d_addr=0x400, d_wdata=0x0000_0005 -> ram_en stays 0; tx_data=0x05 and tx_valid=1 for exactly one cycle coinciding with d_ready.
REQ-046 Scenario: d_we=1, d_addr=0x1004, d_wdata=0xDEADBEEF, ADDR_W=10 -> ram_we=1, ram_addr=0x001 (alias), ram_wdata=0xDEADBEEF; tx_valid stays 0.
REQ-047 Scenario: rst_n dropped while in D_WAIT -> d_ready falls immediately; after release no d_ready until a new d_req is granted.
REQ-048 Scenario: d_we=0, d_addr=0x400 -> d_ready=1 with d_rdata=0; tx_data unchanged.
